mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator side of the operational memory's data-access port.
- Accepts load/store requests from the execute stage over a valid/ready handshake and translates byte addresses to 16-bit word addresses.
- Drives the memAccess* signals of the operational memory. Handles its one-cycle registered read latency.
- Performs byte and halfword stores as read-modify-write, because the memory has no byte enables. Returns sign- or zero-extended load data plus an error flag for misaligned or reserved requests.

Parameters:
- ADDR_W, 18, byte-address width; word address = reqAddr[ADDR_W-1:2], so 16 bits at default.
- DATA_W, 32, memory word width; fixed at 32, other values unsupported.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- reqValid  in  1  request present.
- reqReady  out  1  unit can accept a request.
- reqWrite  in  1  1 = store, 0 = load.
- reqSize  in  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved.
- reqSigned  in  1  sign-extend load result; ignored for word loads and for stores.
- reqAddr  in  ADDR_W  byte address.
- reqData  in  32  store data; the value is in the low bits for byte and halfword stores.
- respValid  out  1  one-cycle response pulse.
- respData  out  32  load result; 0 for stores and errors.
- respError  out  1  request rejected; valid while respValid=1.
- memAccessAddress  out  16  word address to memory.
- memAccessWren  out  1  memory write enable.
- memAccessData  out  32  memory write data.
- memAccessRden  out  1  memory read enable.
- memAccessOutput  in  32  memory read data; valid the cycle after Rden is sampled high.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; respValid=0, respData=0, respError=0.
  - memAccessWren=0, memAccessRden=0, memAccessAddress=0, memAccessData=0.
  - reqReady=1, since it equals (state==IDLE).
- Handshake:
  - A request is accepted on an edge where reqValid&reqReady; all req* fields are captured into registers at that edge.
  - reqReady=0 in every non-IDLE state. One request is in flight at a time.
  - respValid has no backpressure. The consumer must take the response in the cycle it is presented.
- Error check at acceptance: respError is raised for any of
  - reqSize=3;
  - reqSize=1 with addr[0]=1;
  - reqSize=2 with addr[1:0]!=0.
  An errored request makes no memory access and goes IDLE -> RESP (respError=1, respData=0).
- States: IDLE, RD, RD_WAIT, WR, RMW_RD, RMW_MERGE, RESP.
- State transitions from IDLE on acceptance:
  - load -> RD
  - word store -> WR
  - byte/half store -> RMW_RD
- Memory drive rules:
  - Memory-side outputs are decoded from the state and captured registers only, never from req* inputs directly.
  - memAccessAddress = captured addr[17:2] in RD, WR, RMW_RD and RMW_MERGE; 0 otherwise.
  - Rden=1 only in RD and RMW_RD.
  - Wren=1 only in WR. Rden and Wren are never high together.
- Load path:
  - RD (Rden=1) -> RD_WAIT.
  - RD_WAIT samples memAccessOutput, selects the lane, extends it, registers the result into respData, then goes to RESP.
  - Load latency: acceptance edge to respValid = 3 cycles.
- Lane selection (little-endian):
  - Byte at offset k = bits [8k+7:8k].
  - Halfword at offset 0 = [15:0]; at offset 2 = [31:16].
  - reqSigned=1 sign-extends; 0 zero-extends.
- Word store:
  - WR drives Wren=1 and memAccessData=reqData, then goes to RESP. Latency 2.
- Sub-word store:
  - RMW_RD (Rden=1) -> RMW_MERGE.
  - RMW_MERGE replaces the selected lane of memAccessOutput with reqData[7:0] or reqData[15:0] in the merge register, then goes to WR.
  - WR writes the merged word. Latency 4.
- RESP:
  - respValid=1 for exactly one cycle, then unconditionally -> IDLE.
  - respData and respError hold their values until the next RESP.
- Reset mid-operation:
  - Any state returns to IDLE immediately and Wren/Rden drop asynchronously.
  - An interrupted RMW leaves memory unmodified unless WR had already completed an edge.
  - No response is issued for the aborted request.
- Back-to-back requests: the next request can be accepted in the cycle after RESP (IDLE), giving at most one request per 3 cycles for word stores.

Test Plan:
- Load word: memory word 0x0040 = 0xDEADBEEF; req load, size 2, addr 0x00100 -> Rden=1 with address 0x0040 one cycle after accept; respValid 3 cycles after accept with respData=0xDEADBEEF, respError=0.
- Signed and unsigned byte loads: same word, addr 0x00103, size 0 -> signed respData=0xFFFFFFDE; unsigned respData=0x000000DE. Halfword at addr 0x00102, signed -> 0xFFFFDEAD.
- Byte store RMW: word 0x0040 = 0x11223344; store byte 0xAA to addr 0x00101 -> Rden cycle, then Wren cycle with memAccessData=0x1122AA44; respValid 4 cycles after accept; a subsequent load word returns 0x1122AA44.
- Misaligned and reserved requests: word at addr 0x00102; half at 0x00101; size 3 -> respValid 1 cycle after accept with respError=1, respData=0; Wren and Rden stay 0 throughout.
- Handshake: hold reqValid=1 continuously with two word stores -> reqReady low from the accept edge through RESP; second accept occurs 3 cycles after the first; both words are written in order.
- Async reset during RMW_MERGE: pull rst_n low mid-cycle -> Wren/Rden=0 immediately, reqReady=1, no respValid; target word unchanged on readback.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Request/response handshake and operational-memory data-access port of the
// memory access unit. The unit takes the master view; the execute stage and memory take the slave view.
interface mem_access_unit_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 32
);
  logic              reqValid;
  logic              reqReady;
  logic              reqWrite;
  logic [1:0]        reqSize;
  logic              reqSigned;
  logic [ADDR_W-1:0] reqAddr;
  logic [DATA_W-1:0] reqData;
  logic              respValid;
  logic [DATA_W-1:0] respData;
  logic              respError;
  logic [ADDR_W-3:0] memAccessAddress;
  logic              memAccessWren;
  logic [DATA_W-1:0] memAccessData;
  logic              memAccessRden;
  logic [DATA_W-1:0] memAccessOutput;

  modport master (
    input  reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqData, memAccessOutput,
    output reqReady, respValid, respData, respError,
           memAccessAddress, memAccessWren, memAccessData, memAccessRden
  );

  modport slave (
    output reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqData, memAccessOutput,
    input  reqReady, respValid, respData, respError,
           memAccessAddress, memAccessWren, memAccessData, memAccessRden
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator for the operational memory: one request in flight,
// registered-read latency handling, and read-modify-write for sub-word stores.
module mem_access_unit #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 32
) (
  input logic clk,
  input logic rst_n,
  mem_access_unit_if.master bus
);
  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RMW_RD, RMW_MERGE, RESP} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] resp_data_q;
  logic              resp_err_q;
  logic              accept, req_err;

  function automatic logic [31:0] load_lane(input logic [31:0] w, input logic [1:0] off,
                                            input logic [1:0] sz, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (sz)
      2'd0:    load_lane = sgn ? {{24{b[7]}}, b} : {24'd0, b};
      2'd1:    load_lane = sgn ? {{16{h[15]}}, h} : {16'd0, h};
      default: load_lane = w;
    endcase
  endfunction

  function automatic logic [31:0] merge_lane(input logic [31:0] w, input logic [31:0] d,
                                             input logic [1:0] off, input logic [1:0] sz);
    logic [31:0] m;
    m = w;
    if (sz == 2'd0) m[{off, 3'b000} +: 8]   = d[7:0];
    else            m[{off[1], 4'b0000} +: 16] = d[15:0];
    merge_lane = m;
  endfunction

  assign bus.reqReady  = (state == IDLE);
  assign bus.respValid = (state == RESP);
  assign bus.respData  = resp_data_q;
  assign bus.respError = resp_err_q;
  assign accept        = bus.reqValid & bus.reqReady;

  // Misaligned or reserved sizes are rejected before touching memory.
  always_comb begin
    req_err = 1'b0;
    case (bus.reqSize)
      2'd1:    req_err = bus.reqAddr[0];
      2'd2:    req_err = (bus.reqAddr[1:0] != 2'b00);
      2'd3:    req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) begin
        if (req_err)                 state_nxt = RESP;
        else if (!bus.reqWrite)      state_nxt = RD;
        else if (bus.reqSize == 2'd2) state_nxt = WR;
        else                         state_nxt = RMW_RD;
      end
      RD:        state_nxt = RD_WAIT;
      RD_WAIT:   state_nxt = RESP;
      RMW_RD:    state_nxt = RMW_MERGE;
      RMW_MERGE: state_nxt = WR;
      WR:        state_nxt = RESP;
      RESP:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Memory side is a pure decode of state and captured fields, so reset drops it at once.
  always_comb begin
    bus.memAccessAddress = '0;
    bus.memAccessRden    = 1'b0;
    bus.memAccessWren    = 1'b0;
    bus.memAccessData    = '0;
    case (state)
      RD, RMW_RD: begin
        bus.memAccessAddress = addr_q[ADDR_W-1:2];
        bus.memAccessRden    = 1'b1;
      end
      RMW_MERGE: bus.memAccessAddress = addr_q[ADDR_W-1:2];
      WR: begin
        bus.memAccessAddress = addr_q[ADDR_W-1:2];
        bus.memAccessWren    = 1'b1;
        bus.memAccessData    = data_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      size_q      <= '0;
      signed_q    <= 1'b0;
      data_q      <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          addr_q   <= bus.reqAddr;
          size_q   <= bus.reqSize;
          signed_q <= bus.reqSigned;
          data_q   <= bus.reqData;
          if (req_err) begin
            resp_data_q <= '0;
            resp_err_q  <= 1'b1;
          end
        end
        RD_WAIT: begin
          resp_data_q <= load_lane(bus.memAccessOutput, addr_q[1:0], size_q, signed_q);
          resp_err_q  <= 1'b0;
        end
        RMW_MERGE: data_q <= merge_lane(bus.memAccessOutput, data_q, addr_q[1:0], size_q);
        WR: begin
          resp_data_q <= '0;
          resp_err_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural one-cycle-latency memory.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  mem_access_unit_if #(.ADDR_W(18), .DATA_W(32)) bus ();
  mem_access_unit #(.ADDR_W(18), .DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];
  always @(posedge clk) begin
    if (bus.memAccessRden) bus.memAccessOutput <= mem[bus.memAccessAddress];
    if (bus.memAccessWren) mem[bus.memAccessAddress] <= bus.memAccessData;
  end

  // Observations gathered by run_req
  int          rd_cycles, wr_cycles;
  logic [31:0] wdata_seen, first_addr;
  logic        first_rden;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, then watch it for exactly lat samples after the accept edge.
  task automatic run_req(input string tag, input logic wr, input logic [1:0] sz, input logic sgn,
                         input logic [17:0] addr, input logic [31:0] data, input int lat,
                         input logic [31:0] exp_data, input logic exp_err);
    bus.reqValid = 1'b1; bus.reqWrite = wr; bus.reqSize = sz;
    bus.reqSigned = sgn; bus.reqAddr = addr; bus.reqData = data;
    step();
    bus.reqValid = 1'b0;
    rd_cycles = 0; wr_cycles = 0; wdata_seen = '0;
    first_rden = bus.memAccessRden;
    first_addr = 32'(bus.memAccessAddress);
    for (int n = 1; n <= lat; n++) begin
      if (bus.memAccessRden) rd_cycles++;
      if (bus.memAccessWren) begin wr_cycles++; wdata_seen = bus.memAccessData; end
      if (n < lat) begin
        chk({tag, "_early_resp"}, 32'(bus.respValid), 32'd0);
        step();
      end
    end
    chk({tag, "_resp_valid"}, 32'(bus.respValid), 32'd1);
    chk({tag, "_resp_data"}, bus.respData, exp_data);
    chk({tag, "_resp_err"}, 32'(bus.respError), 32'(exp_err));
    step();
    chk({tag, "_back_idle"}, {30'd0, bus.respValid, bus.reqReady}, 32'd1);
  endtask

  initial begin
    bus.reqValid = 1'b0; bus.reqWrite = 1'b0; bus.reqSize = 2'd0;
    bus.reqSigned = 1'b0; bus.reqAddr = '0; bus.reqData = '0;
    #3;
    chk("rst_ready", 32'(bus.reqReady), 32'd1);
    chk("rst_resp_valid", 32'(bus.respValid), 32'd0);
    chk("rst_resp_data", bus.respData, 32'd0);
    chk("rst_resp_err", 32'(bus.respError), 32'd0);
    chk("rst_mem_en", {30'd0, bus.memAccessWren, bus.memAccessRden}, 32'd0);
    chk("rst_mem_addr", 32'(bus.memAccessAddress), 32'd0);
    chk("rst_mem_data", bus.memAccessData, 32'd0);
    #4 rst_n = 1'b1;
    step();

    // Word store then word load
    run_req("st_word", 1'b1, 2'd2, 1'b0, 18'h00100, 32'hDEADBEEF, 2, 32'd0, 1'b0);
    chk("st_word_wdata", wdata_seen, 32'hDEADBEEF);
    chk("st_word_wcnt", 32'(wr_cycles), 32'd1);
    chk("st_word_rcnt", 32'(rd_cycles), 32'd0);
    run_req("ld_word", 1'b0, 2'd2, 1'b0, 18'h00100, 32'd0, 3, 32'hDEADBEEF, 1'b0);
    chk("ld_word_rden1", 32'(first_rden), 32'd1);
    chk("ld_word_addr1", first_addr, 32'h0040);

    // Sub-word loads with sign/zero extension
    run_req("ld_b3_s", 1'b0, 2'd0, 1'b1, 18'h00103, 32'd0, 3, 32'hFFFFFFDE, 1'b0);
    run_req("ld_b3_u", 1'b0, 2'd0, 1'b0, 18'h00103, 32'd0, 3, 32'h000000DE, 1'b0);
    run_req("ld_h2_s", 1'b0, 2'd1, 1'b1, 18'h00102, 32'd0, 3, 32'hFFFFDEAD, 1'b0);
    run_req("ld_h0_u", 1'b0, 2'd1, 1'b0, 18'h00100, 32'd0, 3, 32'h0000BEEF, 1'b0);
    run_req("ld_b0_s", 1'b0, 2'd0, 1'b1, 18'h00100, 32'd0, 3, 32'hFFFFFFEF, 1'b0);
    run_req("ld_b1_u", 1'b0, 2'd0, 1'b0, 18'h00101, 32'd0, 3, 32'h000000BE, 1'b0);
    run_req("ld_word_s", 1'b0, 2'd2, 1'b1, 18'h00100, 32'd0, 3, 32'hDEADBEEF, 1'b0);

    // Read-modify-write stores; upper store-data bits must be ignored
    run_req("st_init", 1'b1, 2'd2, 1'b0, 18'h00100, 32'h11223344, 2, 32'd0, 1'b0);
    run_req("st_byte", 1'b1, 2'd0, 1'b0, 18'h00101, 32'hFFFFFFAA, 4, 32'd0, 1'b0);
    chk("st_byte_wdata", wdata_seen, 32'h1122AA44);
    chk("st_byte_rcnt", 32'(rd_cycles), 32'd1);
    chk("st_byte_wcnt", 32'(wr_cycles), 32'd1);
    run_req("rb_byte", 1'b0, 2'd2, 1'b0, 18'h00100, 32'd0, 3, 32'h1122AA44, 1'b0);
    run_req("st_half", 1'b1, 2'd1, 1'b0, 18'h00102, 32'hABCD5566, 4, 32'd0, 1'b0);
    chk("st_half_wdata", wdata_seen, 32'h5566AA44);
    run_req("rb_half", 1'b0, 2'd2, 1'b0, 18'h00100, 32'd0, 3, 32'h5566AA44, 1'b0);

    // Rejected requests: no memory activity, response in the first cycle
    run_req("err_word", 1'b0, 2'd2, 1'b0, 18'h00102, 32'd0, 1, 32'd0, 1'b1);
    chk("err_word_mem", 32'(rd_cycles + wr_cycles), 32'd0);
    run_req("err_half", 1'b1, 2'd1, 1'b0, 18'h00101, 32'h1234, 1, 32'd0, 1'b1);
    chk("err_half_mem", 32'(rd_cycles + wr_cycles), 32'd0);
    run_req("err_rsvd", 1'b0, 2'd3, 1'b0, 18'h00100, 32'd0, 1, 32'd0, 1'b1);
    chk("err_rsvd_mem", 32'(rd_cycles + wr_cycles), 32'd0);
    run_req("rb_after_err", 1'b0, 2'd2, 1'b0, 18'h00100, 32'd0, 3, 32'h5566AA44, 1'b0);

    // Back-to-back word stores with reqValid held high
    bus.reqValid = 1'b1; bus.reqWrite = 1'b1; bus.reqSize = 2'd2; bus.reqSigned = 1'b0;
    bus.reqAddr = 18'h00200; bus.reqData = 32'hA5A5A5A5;
    step();
    bus.reqAddr = 18'h00204; bus.reqData = 32'h5A5A5A5A;
    chk("b2b_ready1", 32'(bus.reqReady), 32'd0);
    chk("b2b_wr_addr", 32'(bus.memAccessAddress), 32'h0080);
    step();
    chk("b2b_ready2", {30'd0, bus.respValid, bus.reqReady}, 32'd2);
    step();
    chk("b2b_ready3", 32'(bus.reqReady), 32'd1);
    step();
    bus.reqValid = 1'b0;
    chk("b2b_second_wr", {15'd0, bus.memAccessWren, bus.memAccessAddress}, 32'h10081);
    step();
    chk("b2b_second_resp", 32'(bus.respValid), 32'd1);
    step();
    run_req("rb_b2b_a", 1'b0, 2'd2, 1'b0, 18'h00200, 32'd0, 3, 32'hA5A5A5A5, 1'b0);
    run_req("rb_b2b_b", 1'b0, 2'd2, 1'b0, 18'h00204, 32'd0, 3, 32'h5A5A5A5A, 1'b0);

    // Asynchronous reset while in RMW_MERGE
    run_req("st_rst_init", 1'b1, 2'd2, 1'b0, 18'h00300, 32'h01020304, 2, 32'd0, 1'b0);
    bus.reqValid = 1'b1; bus.reqWrite = 1'b1; bus.reqSize = 2'd0;
    bus.reqAddr = 18'h00300; bus.reqData = 32'h000000FF;
    step();
    bus.reqValid = 1'b0;
    chk("rst_mid_rmw_rd", 32'(bus.memAccessRden), 32'd1);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_en", {30'd0, bus.memAccessWren, bus.memAccessRden}, 32'd0);
    chk("rst_mid_ready", 32'(bus.reqReady), 32'd1);
    chk("rst_mid_resp", 32'(bus.respValid), 32'd0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_no_resp", {30'd0, bus.respValid, bus.memAccessWren}, 32'd0);
    end
    run_req("rb_rst", 1'b0, 2'd2, 1'b0, 18'h00300, 32'd0, 3, 32'h01020304, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
